lfsr_burst_ctrl: RTL
====================

Name: lfsr_burst_ctrl

Overview:
- Request-driven sequencer for a 16-bit Galois LFSR random-word source.
- A requester asks for N words, optionally reseeding first. The block steps the LFSR once per accepted output word and presents the words on a valid/ready stream with a last marker.
- It sits between the software-facing control regs and any consumer of pseudo-random data, and holds the LFSR state across bursts.

Parameters:
- WIDTH, 16, LFSR and output word width.
- POLY_N, 16'hB400, Galois tap mask. Bit i (i<WIDTH-1) is XORed into next[i]. Bit WIDTH-1 is unused.
- SEED, 16'hACE1, LFSR value after reset. Also substituted when a zero seed is requested.
- CNT_W, 8, width of the burst length field.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  block can accept a request.
- req_count  in  CNT_W  number of words requested. 0 is legal.
- req_seed_load  in  1  load req_seed into LFSR on acceptance.
- req_seed  in  WIDTH  seed value.
- abort  in  1  terminate current burst.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  WIDTH  current LFSR state.
- out_last  out  1  final word of burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- seed_err  out  1  one-cycle pulse: zero seed was replaced by SEED.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, lfsr=SEED, remaining count=0, req_ready=1. All other outputs are 0. Reset mid-burst abandons the burst silently, with no done pulse.
- LFSR step, applied only on an output handshake (out_valid & out_ready):
  - next[i] = lfsr[i+1] ^ (POLY_N[i] & lfsr[0]) for i<WIDTH-1.
  - next[WIDTH-1] = lfsr[0].
- out_data = lfsr register, combinationally.
- FSM states: IDLE, RUN.
- IDLE:
  - req_ready=1, out_valid=0, busy=0.
  - Acceptance happens when req_valid & req_ready.
  - On acceptance with req_seed_load=1: lfsr<=req_seed. If req_seed==0, lfsr<=SEED and seed_err pulses the next cycle.
  - On acceptance with req_seed_load=0: lfsr is unchanged and persists from the previous burst.
  - Acceptance with req_count==0: stay IDLE, done=1 next cycle, no words produced.
  - Acceptance with req_count>0: remaining<=req_count, go to RUN.
- RUN:
  - req_ready=0, busy=1, out_valid=1.
  - out_last = (remaining==1).
  - The first word appears the cycle after acceptance.
  - On each handshake: lfsr steps and remaining decrements.
  - Handshake with remaining==1: go to IDLE, done=1 next cycle.
  - out_data and out_last are held stable while out_valid & !out_ready.
- abort in RUN: go to IDLE next cycle, out_valid drops, done=1. Any handshake in the abort cycle is ignored, so the LFSR does not step. abort in IDLE is ignored.
- Simultaneous abort and rst: rst wins.
- Back-to-back bursts: req_ready returns in the same cycle done pulses. A new request can be accepted that cycle.
- Throughput: one word per clock with out_ready held high.
- Latency: request accepted at edge T produces the first word valid in cycle T+1.

Test Plan:
- Reset, then request count=3, seed_load=0, out_ready=1 -> out_data 0xACE1, 0xE270, 0x7138 on consecutive cycles. out_last on the third word. done pulses the cycle after. busy=1 for exactly 3 cycles.
- Same burst with out_ready toggling 1,0,0,1,1 -> words unchanged and held stable during stalls, 3 handshakes total, LFSR ends at 0x389C.
- Request seed_load=1 with req_seed=0x0000 -> seed_err pulse, first word 0xACE1. Then seed_load=1 with req_seed=0x0001, count=1 -> word 0x0001, next burst starts at 0xB400.
- Request count=0 -> no out_valid, done pulses at T+1, req_ready never drops.
- Count=5 burst, abort after the 2nd handshake -> out_valid low next cycle, done pulse, a following seed_load=0 burst starts at the 3rd LFSR value (0x7138).
- rst asserted mid-burst (count=4, after 1 word) -> next cycle IDLE, out_valid=0, no done, next burst starts at 0xACE1.

Source files
------------

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for a Galois LFSR word source. A request asks for N words,
// optionally reseeding first. Each accepted output word steps the LFSR once.
module lfsr_burst_ctrl #(
  parameter int              WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY_N = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
  parameter int              CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic             req_seed_load,
  input  logic [WIDTH-1:0] req_seed,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             seed_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and out_data/out_last stay
  // stable while out_valid is high and out_ready is low.

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             seed_err_q, seed_err_d;

  // Galois step: shift toward bit 0, feed bit 0 back through the tap mask.
  always_comb begin
    lfsr_step = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      lfsr_step[i] = lfsr_q[i+1] ^ (POLY_N[i] & lfsr_q[0]);
    end
    lfsr_step[WIDTH-1] = lfsr_q[0];
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    seed_err_d  = 1'b0;
    req_ready   = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_seed_load) begin
            // An all-zero LFSR would lock up, so substitute the reset seed.
            if (req_seed == '0) begin
              lfsr_d     = SEED;
              seed_err_d = 1'b1;
            end else begin
              lfsr_d = req_seed;
            end
          end
          if (req_count == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = req_count;
            state_d     = RUN;
          end
        end
      end

      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (remaining_q == CNT_W'(1));
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (out_ready) begin
          lfsr_d      = lfsr_step;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      remaining_q <= '0;
      done_q      <= 1'b0;
      seed_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      seed_err_q  <= seed_err_d;
    end
  end

  assign out_data = lfsr_q;
  assign done     = done_q;
  assign seed_err = seed_err_q;

endmodule
